// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encodings and constants for pipe_ctrl
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    PC_ST_RUN      = 1'b0,
    PC_ST_BUS_HOLD = 1'b1
  } pc_state_e;

  localparam logic HoldEnable   = 1'b1;
  localparam logic HoldDisable  = 1'b0;
  localparam logic FlushEnable  = 1'b1;
  localparam logic FlushDisable = 1'b0;

  localparam logic [31:0] ZeroWord         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_PC  = 32'h0000_0100;
  localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

endpackage

// File: rtl/pipe_ctrl_pc_reg.sv
// rtl/pipe_ctrl_pc_reg.sv - fetch PC register with redirect > hold > sequential mux
module pipe_ctrl_pc_reg
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jmp_i,
  input  logic [31:0] target_i,
  input  logic        hold_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  always_comb begin
    pc_d = pc_q + PC_STEP;
    if (jmp_i) begin
      pc_d = target_i;
    end else if (hold_i) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - PC, flush/hold, bus freeze handshake and misaligned-jump trap
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_PC  = DEFAULT_TRAP_PC,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] jump_addr_i,
  input  logic        jump_en_i,
  input  logic        hold_flag_i,
  input  logic        bus_hold_req_i,
  output logic        bus_hold_ack_o,
  output logic [31:0] pc_o,
  output logic        flush_o,
  output logic        hold_o,
  output logic        misalign_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] err_addr_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] stall_cnt_o
`else
  output logic [31:0] err_addr_o
`endif
);

  pc_state_e   state_d, state_q;
  logic        ack_d, ack_q;
  logic        misalign_d, misalign_q;
  logic [31:0] err_addr_d, err_addr_q;
  logic        jmp;
  logic        hold;
  logic        misaligned;
  logic [31:0] target;

  // rst_n gates the combinational outputs so they read 0 while reset is held
  always_comb begin
    jmp        = rst_n & jump_en_i & ~hold_flag_i & (state_q == PC_ST_RUN);
    hold       = rst_n & (hold_flag_i | (state_q == PC_ST_BUS_HOLD));
    misaligned = |jump_addr_i[1:0];
    target     = misaligned ? TRAP_PC : jump_addr_i;
    flush_o    = jmp ? FlushEnable : FlushDisable;
    hold_o     = hold ? HoldEnable : HoldDisable;
  end

  always_comb begin
    state_d    = state_q;
    misalign_d = misalign_q;
    err_addr_d = err_addr_q;
    case (state_q)
      PC_ST_RUN: begin
        if (bus_hold_req_i && !jump_en_i && !hold_flag_i) begin
          state_d = PC_ST_BUS_HOLD;
        end
      end
      PC_ST_BUS_HOLD: begin
        if (!bus_hold_req_i) begin
          state_d = PC_ST_RUN;
        end
      end
      default: state_d = PC_ST_RUN;
    endcase
    ack_d = (state_d == PC_ST_BUS_HOLD);
    // only the first offending target is captured until the next reset
    if (jmp && misaligned && !misalign_q) begin
      misalign_d = 1'b1;
      err_addr_d = jump_addr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PC_ST_RUN;
      ack_q      <= 1'b0;
      misalign_q <= 1'b0;
      err_addr_q <= ZeroWord;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      misalign_q <= misalign_d;
      err_addr_q <= err_addr_d;
    end
  end

  pipe_ctrl_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .jmp_i    (jmp),
    .target_i (target),
    .hold_i   (hold),
    .pc_o     (pc_o)
  );

  assign bus_hold_ack_o = ack_q;
  assign misalign_o     = misalign_q;
  assign err_addr_o     = err_addr_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] flush_cnt_d, flush_cnt_q;
  logic [31:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    flush_cnt_d = flush_cnt_q + (jmp ? 32'd1 : ZeroWord);
    stall_cnt_d = stall_cnt_q + (hold ? 32'd1 : ZeroWord);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_q <= ZeroWord;
      stall_cnt_q <= ZeroWord;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flush_cnt_o = flush_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl with hand-computed vectors
module tb_pipe_ctrl;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic        flush;
    logic        hold;
    logic        ack;
    logic        mis;
    logic [31:0] err;
    logic [31:0] fc;
    logic [31:0] sc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] jump_addr_i;
  logic        jump_en_i;
  logic        hold_flag_i;
  logic        bus_hold_req_i;
  logic        bus_hold_ack_o;
  logic [31:0] pc_o;
  logic        flush_o;
  logic        hold_o;
  logic        misalign_o;
  logic [31:0] err_addr_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] flush_cnt_o;
  logic [31:0] stall_cnt_o;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb_q[$];

  pipe_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .jump_addr_i    (jump_addr_i),
    .jump_en_i      (jump_en_i),
    .hold_flag_i    (hold_flag_i),
    .bus_hold_req_i (bus_hold_req_i),
    .bus_hold_ack_o (bus_hold_ack_o),
    .pc_o           (pc_o),
    .flush_o        (flush_o),
    .hold_o         (hold_o),
    .misalign_o     (misalign_o),
`ifdef PIPE_CTRL_PERF_EN
    .err_addr_o     (err_addr_o),
    .flush_cnt_o    (flush_cnt_o),
    .stall_cnt_o    (stall_cnt_o)
`else
    .err_addr_o     (err_addr_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, c, act, exp);
    end
  endtask

  // drive one cycle of inputs, queue the outputs expected during that cycle, advance
  task automatic step(input logic jen, input logic [31:0] jaddr, input logic hf, input logic breq,
                      input logic [31:0] e_pc, input logic e_fl, input logic e_ho, input logic e_ack,
                      input logic e_mis, input logic [31:0] e_err, input int e_fc, input int e_sc);
    exp_t e;
    jump_en_i      = jen;
    jump_addr_i    = jaddr;
    hold_flag_i    = hf;
    bus_hold_req_i = breq;
    e.cyc = cyc; e.pc = e_pc; e.flush = e_fl; e.hold = e_ho; e.ack = e_ack;
    e.mis = e_mis; e.err = e_err; e.fc = 32'(e_fc); e.sc = 32'(e_sc);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc", e.cyc, pc_o, e.pc);
        chk("flush", e.cyc, 32'(flush_o), 32'(e.flush));
        chk("hold", e.cyc, 32'(hold_o), 32'(e.hold));
        chk("ack", e.cyc, 32'(bus_hold_ack_o), 32'(e.ack));
        chk("misalign", e.cyc, 32'(misalign_o), 32'(e.mis));
        chk("err_addr", e.cyc, err_addr_o, e.err);
`ifdef PIPE_CTRL_PERF_EN
        chk("flush_cnt", e.cyc, flush_cnt_o, e.fc);
        chk("stall_cnt", e.cyc, stall_cnt_o, e.sc);
`endif
      end
    end
  end

  task automatic drain();
    int budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    checks++;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
  endtask

  initial begin : stim
    rst_n = 1'b0;
    jump_en_i = 1'b1; jump_addr_i = 32'h40; hold_flag_i = 1'b1; bus_hold_req_i = 1'b0;
    #2;
    chk("rst_pc", -1, pc_o, 32'h0);
    chk("rst_ack", -1, 32'(bus_hold_ack_o), 32'h0);
    chk("rst_flush", -1, 32'(flush_o), 32'h0);
    chk("rst_hold", -1, 32'(hold_o), 32'h0);
    chk("rst_misalign", -1, 32'(misalign_o), 32'h0);
    chk("rst_err", -1, err_addr_o, 32'h0);
    jump_en_i = 1'b0; hold_flag_i = 1'b0; jump_addr_i = 32'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    //    jen  addr    hf   breq pc        fl   ho   ack  mis  err     fc sc
    step(1'b0, 32'h0,   1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  0, 0);
    step(1'b0, 32'h0,   1'b0, 1'b0, 32'h004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  0, 0);
    step(1'b0, 32'h0,   1'b0, 1'b0, 32'h008, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  0, 0);
    step(1'b0, 32'h0,   1'b0, 1'b0, 32'h00C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  0, 0);
    step(1'b1, 32'h40,  1'b0, 1'b0, 32'h010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  0, 0);
    step(1'b0, 32'h0,   1'b0, 1'b0, 32'h040, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1, 0);
    step(1'b0, 32'h0,   1'b0, 1'b0, 32'h044, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1, 0);
    // hold beats a simultaneous jump; jump is taken once hold drops
    step(1'b1, 32'h80,  1'b1, 1'b0, 32'h048, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1, 0);
    step(1'b1, 32'h80,  1'b1, 1'b0, 32'h048, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1, 1);
    step(1'b1, 32'h80,  1'b1, 1'b0, 32'h048, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1, 2);
    step(1'b1, 32'h80,  1'b0, 1'b0, 32'h048, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1, 3);
    step(1'b0, 32'h0,   1'b0, 1'b0, 32'h080, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  2, 3);
    step(1'b0, 32'h0,   1'b0, 1'b0, 32'h084, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  2, 3);
    // bus request with a jump in flight: grant is delayed one cycle
    step(1'b1, 32'h200, 1'b0, 1'b1, 32'h088, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  2, 3);
    step(1'b0, 32'h0,   1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  3, 3);
    step(1'b0, 32'h0,   1'b0, 1'b1, 32'h204, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  3, 3);
    step(1'b1, 32'h300, 1'b0, 1'b1, 32'h204, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  3, 4);
    step(1'b0, 32'h0,   1'b0, 1'b0, 32'h204, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  3, 5);
    step(1'b0, 32'h0,   1'b0, 1'b0, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  3, 6);
    step(1'b0, 32'h0,   1'b0, 1'b0, 32'h208, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  3, 6);
    // request withdrawn while EX hold blocks it: never granted
    step(1'b0, 32'h0,   1'b1, 1'b1, 32'h20C, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  3, 6);
    step(1'b0, 32'h0,   1'b0, 1'b0, 32'h20C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  3, 7);
    step(1'b0, 32'h0,   1'b0, 1'b0, 32'h210, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  3, 7);
    // misaligned jumps trap; first offending address is kept
    step(1'b1, 32'h42,  1'b0, 1'b0, 32'h214, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  3, 7);
    step(1'b0, 32'h0,   1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 32'h42, 4, 7);
    step(1'b1, 32'h13,  1'b0, 1'b0, 32'h104, 1'b1, 1'b0, 1'b0, 1'b1, 32'h42, 4, 7);
    step(1'b0, 32'h0,   1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 32'h42, 5, 7);
    step(1'b0, 32'h0,   1'b0, 1'b0, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 32'h42, 5, 7);
    step(1'b0, 32'h0,   1'b0, 1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 1'b1, 32'h42, 5, 7);
    step(1'b0, 32'h0,   1'b0, 1'b1, 32'h10C, 1'b0, 1'b1, 1'b1, 1'b1, 32'h42, 5, 7);
    drain();

    // asynchronous reset in the middle of BUS_HOLD, checked before any edge
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", cyc, pc_o, 32'h0);
    chk("arst_ack", cyc, 32'(bus_hold_ack_o), 32'h0);
    chk("arst_hold", cyc, 32'(hold_o), 32'h0);
    chk("arst_misalign", cyc, 32'(misalign_o), 32'h0);
    chk("arst_err", cyc, err_addr_o, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
    chk("arst_flush_cnt", cyc, flush_cnt_o, 32'h0);
    chk("arst_stall_cnt", cyc, stall_cnt_o, 32'h0);
`endif
    bus_hold_req_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 32'h0,   1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  0, 0);
    step(1'b0, 32'h0,   1'b0, 1'b0, 32'h004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
